// File: rtl/i2c_target_rx_tx.sv
// I2C target with a fixed 7-bit address: receives write bytes into rx_data and
// sends a 16-bit read payload (then 8'hFF) on read transfers. SCL is never stretched.
module i2c_target_rx_tx #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        SCL,
    inout  wire         SDA,
    input  logic [15:0] tx_data,
    output logic        tx_load,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        busy,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        RX_DATA   = 3'd3,
        RX_ACK    = 3'd4,
        TX_DATA   = 3'd5,
        TX_ACK    = 3'd6,
        WAIT_STOP = 3'd7
    } state_t;

    // Handshake: rx_valid and tx_load are single-cycle strobes with no back-pressure;
    // rx_data is valid in the rx_valid cycle and holds until the next byte.

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [15:0] tx_shift_q, tx_shift_d;
    logic        rw_q, rw_d;
    logic        phase_q, phase_d;
    logic        drive_q, drive_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        tx_load_q, tx_load_d;

    logic scl_meta_q, scl_meta_d;
    logic scl_sync_q, scl_sync_d;
    logic scl_prev_q, scl_prev_d;
    logic sda_meta_q, sda_meta_d;
    logic sda_sync_q, sda_sync_d;
    logic sda_prev_q, sda_prev_d;

    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;
    logic [7:0] in_byte;

    assign SDA       = drive_q ? 1'b0 : 1'bz;
    assign tx_load   = tx_load_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

    assign scl_rise  = scl_sync_q & ~scl_prev_q;
    assign scl_fall  = ~scl_sync_q & scl_prev_q;
    assign start_det = ~sda_sync_q & sda_prev_q & scl_sync_q & scl_prev_q;
    assign stop_det  = sda_sync_q & ~sda_prev_q & scl_sync_q & scl_prev_q;
    assign in_byte   = {shift_q[6:0], sda_sync_q};

    always_comb begin
        scl_meta_d = SCL;
        scl_sync_d = scl_meta_q;
        scl_prev_d = scl_sync_q;
        sda_meta_d = SDA;
        sda_sync_d = sda_meta_q;
        sda_prev_d = sda_sync_q;

        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_shift_d = tx_shift_q;
        rw_d       = rw_q;
        phase_d    = phase_q;
        drive_d    = drive_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_load_d  = 1'b0;

        if (stop_det) begin
            state_d = IDLE;
            drive_d = 1'b0;
        end else if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = 3'd0;
            phase_d   = 1'b0;
            drive_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    drive_d = 1'b0;
                end

                ADDR: begin
                    if (scl_rise) begin
                        shift_d   = in_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (in_byte[7:1] == SLAVE_ADDR) begin
                                state_d = ADDR_ACK;
                                rw_d    = in_byte[0];
                                phase_d = 1'b0;
                                if (in_byte[0]) begin
                                    tx_load_d  = 1'b1;
                                    tx_shift_d = tx_data;
                                end
                            end else begin
                                state_d = WAIT_STOP;
                            end
                        end
                    end
                end

                // phase_q=0: waiting for the fall that starts the ACK slot;
                // phase_q=1: ACK is on the bus until the fall that ends it.
                ADDR_ACK, RX_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            drive_d = 1'b1;
                            phase_d = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            if (state_q == ADDR_ACK && rw_q) begin
                                state_d    = TX_DATA;
                                drive_d    = ~tx_shift_q[15];
                                tx_shift_d = {tx_shift_q[14:0], 1'b1};
                                bit_cnt_d  = bit_cnt_q + 3'd1;
                            end else begin
                                state_d = RX_DATA;
                                drive_d = 1'b0;
                            end
                        end
                    end
                end

                RX_DATA: begin
                    if (scl_rise) begin
                        shift_d   = in_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d  = in_byte;
                            rx_valid_d = 1'b1;
                            state_d    = RX_ACK;
                            phase_d    = 1'b0;
                        end
                    end
                end

                // The payload shifts in ones behind it, so bytes past the second read as FF.
                TX_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd0) begin
                            drive_d = 1'b0;
                            state_d = TX_ACK;
                            phase_d = 1'b0;
                        end else begin
                            drive_d    = ~tx_shift_q[15];
                            tx_shift_d = {tx_shift_q[14:0], 1'b1};
                            bit_cnt_d  = bit_cnt_q + 3'd1;
                        end
                    end
                end

                // phase_q here records that the initiator ACKed on the last rise.
                TX_ACK: begin
                    if (scl_rise) begin
                        if (sda_sync_q) begin
                            state_d = WAIT_STOP;
                            drive_d = 1'b0;
                        end else begin
                            phase_d = 1'b1;
                        end
                    end else if (scl_fall && phase_q) begin
                        state_d    = TX_DATA;
                        phase_d    = 1'b0;
                        drive_d    = ~tx_shift_q[15];
                        tx_shift_d = {tx_shift_q[14:0], 1'b1};
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                    end
                end

                WAIT_STOP: begin
                    drive_d = 1'b0;
                end

                default: begin
                    state_d = IDLE;
                    drive_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            tx_shift_q <= 16'h0000;
            rw_q       <= 1'b0;
            phase_q    <= 1'b0;
            drive_q    <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_load_q  <= 1'b0;
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_shift_q <= tx_shift_d;
            rw_q       <= rw_d;
            phase_q    <= phase_d;
            drive_q    <= drive_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_load_q  <= tx_load_d;
            scl_meta_q <= scl_meta_d;
            scl_sync_q <= scl_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_meta_q <= sda_meta_d;
            sda_sync_q <= sda_sync_d;
            sda_prev_q <= sda_prev_d;
        end
    end

endmodule
